branch_resolve_unit: RTL and testbench

//  Branch sequencer directly downstream of the CON flip-flop. On a request from the

---
 rtl/branch_resolve_unit.sv | 103 ++++++++++
 tb/tb_branch_resolve_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch sequencer behind the CON flip-flop: strobes CONin, samples the condition,
// computes PC + sext(C) and issues a one-cycle PC load when taken; keeps saturating stats.
module branch_resolve_unit #(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 19,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              con_q,
  input  logic [31:0]       ir,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              con_in,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_out,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  tk_cnt
);

  // state   | meaning
  // IDLE    | waiting for start
  // EVAL    | CONin strobed, CON flip-flop captures at the end of this cycle
  // SAMPLE  | CON result settled; latch decision and target
  // RESOLVE | done pulse, PC load if taken, statistics update
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EVAL    = 2'd1,
    S_SAMPLE  = 2'd2,
    S_RESOLVE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              taken_q, taken_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  tk_cnt_q, tk_cnt_d;
  logic [ADDR_W-1:0] c_sext;
  logic              unused_ir;

  assign c_sext    = {{(ADDR_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign unused_ir = ^ir[31:IMM_W];

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      taken_q  <= 1'b0;
      pc_out_q <= '0;
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      taken_q  <= taken_d;
      pc_out_q <= pc_out_d;
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_EVAL;
      S_EVAL:    state_d = S_SAMPLE;
      S_SAMPLE:  state_d = S_RESOLVE;
      S_RESOLVE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Target is computed even when not taken; the sum wraps silently.
  always_comb begin
    taken_d  = taken_q;
    pc_out_d = pc_out_q;
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (state_q == S_SAMPLE) begin
      taken_d  = con_q;
      pc_out_d = pc_in + c_sext;
    end
    if (state_q == S_RESOLVE) begin
      if (br_cnt_q != {CNT_W{1'b1}}) br_cnt_d = br_cnt_q + CNT_ONE;
      if (taken_q && (tk_cnt_q != {CNT_W{1'b1}})) tk_cnt_d = tk_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    con_in  = (state_q == S_EVAL);
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_RESOLVE);
    pc_load = (state_q == S_RESOLVE) && taken_q;
    taken   = taken_q;
    pc_out  = pc_out_q;
    br_cnt  = br_cnt_q;
    tk_cnt  = tk_cnt_q;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: timeline model checked every cycle, plus literal checks.
// A second instance with 3-bit counters exercises saturation within a short run.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        con_q = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] pc_in = '0;

  logic        con_in, busy, done, taken, pc_load;
  logic [31:0] pc_out;
  logic [15:0] br_cnt, tk_cnt;

  logic        con_in_s, busy_s, done_s, taken_s, pc_load_s;
  logic [31:0] pc_out_s;
  logic [2:0]  br_cnt_s, tk_cnt_s;

  branch_resolve_unit dut (
    .clk(clk), .clr(clr), .start(start), .con_q(con_q), .ir(ir), .pc_in(pc_in),
    .con_in(con_in), .busy(busy), .done(done), .taken(taken), .pc_load(pc_load),
    .pc_out(pc_out), .br_cnt(br_cnt), .tk_cnt(tk_cnt)
  );

  branch_resolve_unit #(.CNT_W(3)) dut_s (
    .clk(clk), .clr(clr), .start(start), .con_q(con_q), .ir(ir), .pc_in(pc_in),
    .con_in(con_in_s), .busy(busy_s), .done(done_s), .taken(taken_s), .pc_load(pc_load_s),
    .pc_out(pc_out_s), .br_cnt(br_cnt_s), .tk_cnt(tk_cnt_s)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an operation accepted at edge N is described purely by its distance from N.
  bit          chk_en = 1'b0;
  bit          m_act = 1'b0;
  int          cyc = 0;
  int          op_start = 0;
  bit          m_taken = 1'b0;
  logic [31:0] m_pc = '0;
  int          m_br = 0, m_tk = 0, m_brs = 0, m_tks = 0;
  bit          e_con_in = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_pc_load = 1'b0;

  always @(posedge clk) begin
    if (!clr) begin
      m_act = 1'b0; m_taken = 1'b0; m_pc = '0;
      m_br = 0; m_tk = 0; m_brs = 0; m_tks = 0;
      chk_en = 1'b1;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1;
        op_start = cyc;
      end
    end else begin
      if (cyc - op_start == 2) begin
        m_taken = con_q;
        m_pc = pc_in + 32'($signed(ir[18:0]));
      end
      if (cyc - op_start == 3) begin
        if (m_br < 65535) m_br++;
        if (m_brs < 7) m_brs++;
        if (m_taken) begin
          if (m_tk < 65535) m_tk++;
          if (m_tks < 7) m_tks++;
        end
        m_act = 1'b0;
      end
    end
    e_con_in  = m_act && (cyc == op_start);
    e_busy    = m_act;
    e_done    = m_act && (cyc - op_start == 2);
    e_pc_load = e_done && m_taken;
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("con_in", con_in, e_con_in);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("pc_load", pc_load, e_pc_load);
      check("taken", taken, m_taken);
      check("pc_out", pc_out, m_pc);
      check("br_cnt", br_cnt, 64'(m_br));
      check("tk_cnt", tk_cnt, 64'(m_tk));
      check("br_cnt_small", br_cnt_s, 64'(m_brs));
      check("tk_cnt_small", tk_cnt_s, 64'(m_tks));
    end
  end

  // One request; optional start pulse over the SAMPLE and RESOLVE edges that must be dropped.
  task automatic op(input logic [31:0] pc, input logic [18:0] c, input bit con,
                    input bit pulse_busy, input logic [31:0] exp_pc, input bit exp_tk);
    @(negedge clk); start = 1'b1; pc_in = pc; ir = {13'h0, c}; con_q = con;
    @(negedge clk); start = 1'b0;
    @(negedge clk); if (pulse_busy) start = 1'b1;
    @(negedge clk);
    check("lit_done", done, 1);
    check("lit_pc_load", pc_load, 64'(exp_tk));
    check("lit_taken", taken, 64'(exp_tk));
    if (exp_tk) check("lit_pc_out", pc_out, exp_pc);
    @(negedge clk); start = 1'b0;
    check("lit_idle", busy, 0);
  endtask

  logic [18:0] loop_c [6] = '{19'h00004, 19'h7FFFC, 19'h3FFFF, 19'h40000, 19'h00000, 19'h12345};
  logic [31:0] loop_pc [6] = '{32'h1000, 32'h1000, 32'h0, 32'h80000000, 32'hDEADBEEF, 32'h10};

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    check("lit_reset_busy", busy, 0);
    check("lit_reset_br", br_cnt, 0);
    clr = 1'b1;

    op(32'h100, 19'h00010, 1'b1, 1'b0, 32'h110, 1'b1);
    check("lit_t2_br", br_cnt, 1);
    check("lit_t2_tk", tk_cnt, 1);
    op(32'h100, 19'h7FFF0, 1'b1, 1'b0, 32'h0F0, 1'b1);

    // Reset asserted while in SAMPLE aborts the op.
    @(negedge clk); start = 1'b1; pc_in = 32'h500; ir = 32'h10; con_q = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); clr = 1'b0;
    @(negedge clk); clr = 1'b1;
    check("lit_rst_busy", busy, 0);
    check("lit_rst_done", done, 0);
    check("lit_rst_con_in", con_in, 0);
    check("lit_rst_taken", taken, 0);
    check("lit_rst_pc_load", pc_load, 0);
    check("lit_rst_pc_out", pc_out, 0);
    check("lit_rst_br", br_cnt, 0);
    check("lit_rst_tk", tk_cnt, 0);

    op(32'h300, 19'h00005, 1'b0, 1'b1, 32'h0, 1'b0);
    check("lit_t4_br", br_cnt, 1);
    check("lit_t4_tk", tk_cnt, 0);
    op(32'hFFFFFFF8, 19'h00010, 1'b1, 1'b0, 32'h00000008, 1'b1);

    // start held continuously: ops accepted at N, N+4, N+8.
    nd = 0;
    @(negedge clk); start = 1'b1; pc_in = 32'h2000; ir = 32'h4; con_q = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    start = 1'b0;
    check("lit_held_dones", 64'(nd), 3);
    repeat (2) @(negedge clk);
    check("lit_held_br", br_cnt, 5);

    for (int i = 0; i < 6; i++)
      op(loop_pc[i], loop_c[i], 1'b1, 1'b0, loop_pc[i] + 32'($signed(loop_c[i])), 1'b1);
    check("lit_final_br", br_cnt, 11);
    check("lit_final_tk", tk_cnt, 10);
    check("lit_sat_br_small", br_cnt_s, 7);
    check("lit_sat_tk_small", tk_cnt_s, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
